// File: rtl/router_pkg.sv
// Shared router definitions: port index width, output allocation states and
// the default watchdog limit used by the channel, crossbar and arbiter blocks.
package router_pkg;

  localparam int DEFAULT_TIMEOUT = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } out_state_t;

  // Width of a port index; never below one bit so single-port builds still elaborate.
  function automatic int port_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over COUNT requesters: the search starts at ptr and wraps,
// returning a one-hot grant, the winning index and a hit flag.
module rr_arbiter
  import router_pkg::*;
#(
  parameter int COUNT  = 8,
  parameter int PORT_W = port_w(COUNT)
) (
  input  logic [COUNT-1:0]  req,
  input  logic [PORT_W-1:0] ptr,
  output logic [COUNT-1:0]  gnt,
  output logic [PORT_W-1:0] idx,
  output logic              hit
);

  // First set request at or after ptr, modulo COUNT.
  always_comb begin
    int p;
    logic [PORT_W-1:0] pi;
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    p   = 0;
    pi  = '0;
    for (int k = 0; k < COUNT; k++) begin
      p = int'(ptr) + k;
      if (p >= COUNT) p = p - COUNT;
      pi = PORT_W'(p);
      if (!hit && req[pi]) begin
        hit     = 1'b1;
        idx     = pi;
        gnt[pi] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/route_arbiter.sv
// Router output allocator. Each output owns an IDLE/BUSY FSM and a round-robin
// pointer; a connection is held until the owner ends its packet or aborts.
// Optional feature: define ROUTE_WDOG_EN to add a per-output stall watchdog
// that releases an owner after TIMEOUT cycles without a character moved.
module route_arbiter
  import router_pkg::*;
#(
  parameter int COUNT   = 8,
  parameter int PORT_W  = port_w(COUNT),
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [COUNT-1:0]             req_valid,
  input  logic [COUNT-1:0][PORT_W-1:0] req_dest,
  input  logic [COUNT-1:0]             req_done,
  input  logic [COUNT-1:0]             req_act,
  output logic [COUNT-1:0]             grant,
  output logic [COUNT-1:0]             req_err,
  output logic [COUNT-1:0]             out_busy,
  output logic [COUNT-1:0][PORT_W-1:0] out_owner
);

  logic [COUNT-1:0][COUNT-1:0] pick;   // per output: input taken this cycle
  logic [COUNT-1:0][COUNT-1:0] drop;   // per output: owner released this cycle
  logic [COUNT-1:0]            grant_set, grant_clr;
  logic [COUNT-1:0]            bad, err_seen;
  logic [2**PORT_W-1:0]        dest_ok;

  // Index values at or above COUNT name ports that do not exist.
  for (genvar k = 0; k < 2**PORT_W; k++) begin : g_dest_ok
    assign dest_ok[k] = (k < COUNT);
  end

  for (genvar j = 0; j < COUNT; j++) begin : g_out
    out_state_t        state, state_nxt;
    logic [PORT_W-1:0] ptr, ptr_nxt, owner, owner_nxt;
    logic [COUNT-1:0]  cand, hit_vec;
    logic [PORT_W-1:0] hit_idx;
    logic              hit, wd_fire, owner_stop, rel, take;

    // Ungranted inputs currently asking for this output.
    always_comb begin
      cand = '0;
      for (int i = 0; i < COUNT; i++)
        cand[i] = req_valid[i] && !grant[i] && (req_dest[i] == PORT_W'(j));
    end

    rr_arbiter #(.COUNT(COUNT), .PORT_W(PORT_W)) u_rr (
      .req (cand),
      .ptr (ptr),
      .gnt (hit_vec),
      .idx (hit_idx),
      .hit (hit)
    );

    assign owner_stop = req_done[owner] || !req_valid[owner] || wd_fire;

    // Next state: IDLE grabs the round-robin winner, BUSY waits for release.
    always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      rel       = 1'b0;
      take      = 1'b0;
      case (state)
        IDLE: if (hit) begin
          state_nxt = BUSY;
          owner_nxt = hit_idx;
          ptr_nxt   = (hit_idx == PORT_W'(COUNT - 1)) ? '0 : hit_idx + 1'b1;
          take      = 1'b1;
        end
        BUSY: if (owner_stop) begin
          state_nxt = IDLE;
          owner_nxt = '0;
          rel       = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end

    // State, pointer and owner registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        ptr   <= '0;
        owner <= '0;
      end else begin
        state <= state_nxt;
        ptr   <= ptr_nxt;
        owner <= owner_nxt;
      end
    end

    assign out_busy[j]  = (state == BUSY);
    assign out_owner[j] = owner;
    assign pick[j]      = take ? hit_vec : '0;
    assign drop[j]      = rel ? ({{(COUNT-1){1'b0}}, 1'b1} << owner) : '0;

`ifdef ROUTE_WDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] idle_cnt;

    assign wd_fire = (state == BUSY) && (idle_cnt == CNT_W'(TIMEOUT - 1));

    // Cycles since grant or the owner's last character; idle outputs stay at 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                idle_cnt <= '0;
      else if (state != BUSY || rel || req_act[owner]) idle_cnt <= '0;
      else                                       idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign wd_fire = 1'b0;
`endif
  end

`ifndef ROUTE_WDOG_EN
  logic unused_wdog;
  assign unused_wdog = ^{req_act, TIMEOUT};
`endif

  // Fold per-output grant and release masks; each input targets one output.
  always_comb begin
    grant_set = '0;
    grant_clr = '0;
    for (int j = 0; j < COUNT; j++) begin
      grant_set = grant_set | pick[j];
      grant_clr = grant_clr | drop[j];
    end
  end

  // Requests for nonexistent ports from ungranted inputs.
  always_comb begin
    bad = '0;
    for (int i = 0; i < COUNT; i++)
      bad[i] = req_valid[i] && !grant[i] && !dest_ok[req_dest[i]];
  end

  // Grant levels and once-per-request error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant    <= '0;
      req_err  <= '0;
      err_seen <= '0;
    end else begin
      grant    <= (grant & ~grant_clr) | grant_set;
      req_err  <= bad & ~err_seen;
      err_seen <= req_valid & (err_seen | bad);
    end
  end

endmodule

// File: tb/tb_route_arbiter.sv
// Bench for route_arbiter: an 8-port and a 6-port instance share one stimulus
// stream; a port-level reference model predicts every output each cycle.
module tb_route_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]      req_valid, req_done, req_act;
  logic [7:0][2:0] req_dest;
  logic [7:0]      grant8, err8, busy8;
  logic [7:0][2:0] own8;
  logic [5:0]      grant6, err6, busy6;
  logic [5:0][2:0] own6;

  route_arbiter #(.COUNT(8), .PORT_W(3), .TIMEOUT(TO)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_dest(req_dest),
    .req_done(req_done), .req_act(req_act), .grant(grant8), .req_err(err8),
    .out_busy(busy8), .out_owner(own8));

  route_arbiter #(.COUNT(6), .PORT_W(3), .TIMEOUT(TO)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[5:0]), .req_dest(req_dest[5:0]),
    .req_done(req_done[5:0]), .req_act(req_act[5:0]), .grant(grant6), .req_err(err6),
    .out_busy(busy6), .out_owner(own6));

  int checks = 0;
  int errors = 0;

  // Reference model: per output, who owns it (-1 free), where the search starts,
  // and how long the owner has been silent; per input, whether its error fired.
  int owner [2][8];
  int ptr   [2][8];
  int quiet [2][8];
  bit seen  [2][8];
  logic [7:0]      eg [2], eb [2], ee [2];
  logic [7:0][2:0] eo [2];

  function automatic void build_exp();
    for (int d = 0; d < 2; d++) begin
      eg[d] = '0; eb[d] = '0; eo[d] = '0;
      for (int j = 0; j < 8; j++)
        if (owner[d][j] >= 0) begin
          eb[d][j] = 1'b1;
          eo[d][j] = 3'(owner[d][j]);
          eg[d][owner[d][j]] = 1'b1;
        end
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++) begin
        owner[d][k] = -1; ptr[d][k] = 0; quiet[d][k] = 0; seen[d][k] = 1'b0;
      end
    ee[0] = '0; ee[1] = '0;
    build_exp();
  endfunction

  function automatic void model_step();
    for (int d = 0; d < 2; d++) begin
      int n;
      bit held [8];
      n = (d == 0) ? 8 : 6;
      for (int i = 0; i < 8; i++) held[i] = 1'b0;
      for (int j = 0; j < n; j++) if (owner[d][j] >= 0) held[owner[d][j]] = 1'b1;
      ee[d] = '0;
      for (int i = 0; i < n; i++) begin
        if (!req_valid[i]) seen[d][i] = 1'b0;
        else if (!held[i] && int'(req_dest[i]) >= n) begin
          ee[d][i] = !seen[d][i];
          seen[d][i] = 1'b1;
        end
      end
      for (int j = 0; j < n; j++) begin
        if (owner[d][j] >= 0) begin
          int o;
          bit fire;
          o = owner[d][j];
          fire = 1'b0;
`ifdef ROUTE_WDOG_EN
          fire = (quiet[d][j] == TO - 1);
`endif
          if (req_done[o] || !req_valid[o] || fire) owner[d][j] = -1;
          else quiet[d][j] = req_act[o] ? 0 : quiet[d][j] + 1;
        end else begin
          for (int k = 0; k < n; k++) begin
            int i;
            i = (ptr[d][j] + k) % n;
            if (req_valid[i] && !held[i] && int'(req_dest[i]) == j) begin
              owner[d][j] = i;
              ptr[d][j] = (i + 1) % n;
              quiet[d][j] = 0;
              break;
            end
          end
        end
      end
    end
    build_exp();
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("grant8", 32'(grant8), 32'(eg[0]));
    chk("busy8",  32'(busy8),  32'(eb[0]));
    chk("owner8", 32'(own8),   32'(eo[0]));
    chk("err8",   32'(err8),   32'(ee[0]));
    chk("grant6", 32'(grant6), 32'(eg[1][5:0]));
    chk("busy6",  32'(busy6),  32'(eb[1][5:0]));
    chk("owner6", 32'(own6),   32'(eo[1][5:0]));
    chk("err6",   32'(err6),   32'(ee[1][5:0]));
  endtask

  // One clock: model sees the same pre-edge inputs as the DUTs.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    compare_all();
  endtask

  task automatic release_all();
    req_done = req_valid;
    req_valid = '0;
    tick();
    req_done = '0;
    tick();
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    req_valid = '1; req_done = '0; req_act = '0;
    for (int i = 0; i < 8; i++) req_dest[i] = 3'(7 - i);
    model_reset();

    // Reset held with every input requesting: all outputs stay 0.
    repeat (3) tick();
    chk("rst_outputs", {grant8, busy8, err8, err6}, 32'h0);

    // First grant one cycle after the request.
    req_valid = '0;
    req_valid[2] = 1'b1; req_dest[2] = 3'd5;
    rst_n = 1'b1;
    tick();
    chk("first_grant", 32'(grant8), 32'h04);
    chk("first_owner", 32'(own8[5]), 32'd2);
    release_all();

    // Three-way contention for output 0: 1, 3, 6 with a dead cycle between.
    req_valid[1] = 1'b1; req_dest[1] = 3'd0;
    req_valid[3] = 1'b1; req_dest[3] = 3'd0;
    req_valid[6] = 1'b1; req_dest[6] = 3'd0;
    tick();
    chk("rr_1", 32'(grant8), 32'h02);
    req_done[1] = 1'b1; req_valid[1] = 1'b0;
    tick();
    chk("dead_cycle", 32'(grant8), 32'h00);
    req_done = '0;
    tick();
    chk("rr_3", 32'(grant8), 32'h08);
    req_done[3] = 1'b1; req_valid[3] = 1'b0;
    tick();
    req_done = '0;
    tick();
    chk("rr_6", 32'(grant8), 32'h40);
    req_done[6] = 1'b1; req_valid[6] = 1'b0;
    tick();
    req_done = '0;
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    tick();
    chk("rr_wrap", 32'(grant8), 32'h02);
    release_all();
    release_all();

    // Different outputs granted in parallel.
    req_valid[4] = 1'b1; req_dest[4] = 3'd7;
    req_valid[5] = 1'b1; req_dest[5] = 3'd2;
    tick();
    chk("parallel_grant", 32'(grant8), 32'h30);
    chk("parallel_busy", 32'(busy8), 32'h84);
    release_all();

    // Nonexistent destination on the 6-port instance: one pulse per request.
    req_valid[0] = 1'b1; req_dest[0] = 3'd7;
    tick();
    chk("err_first", 32'(err6), 32'h01);
    chk("err_no_grant", 32'(grant6), 32'h00);
    tick();
    chk("err_once", 32'(err6), 32'h00);
    req_valid[0] = 1'b0;
    tick();
    req_valid[0] = 1'b1;
    tick();
    chk("err_again", 32'(err6), 32'h01);
    release_all();

    // Abort by dropping req_valid, then asynchronous reset mid-packet.
    req_valid[3] = 1'b1; req_dest[3] = 3'd4;
    tick();
    chk("abort_grant", 32'(grant8), 32'h08);
    req_valid[3] = 1'b0;
    tick();
    chk("abort_release", {grant8, busy8}, 32'h0);
    req_valid[3] = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst", {grant8, busy8, grant6, busy6}, 32'h0);
    compare_all();
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Stalled owner: released by the watchdog, otherwise held indefinitely.
    req_valid[2] = 1'b1; req_dest[2] = 3'd1;
    tick();
    chk("stall_grant", 32'(grant8[2]), 32'h1);
    cyc = 0;
    while (grant8[2] && cyc < 40) begin
      tick();
      cyc++;
    end
`ifdef ROUTE_WDOG_EN
    chk("wdog_release", 32'(cyc), 32'd16);
`else
    chk("stall_hold", 32'(grant8[2]), 32'h1);
`endif
    release_all();

    // Regular activity keeps the connection alive.
    req_valid[2] = 1'b1;
    tick();
    for (int k = 0; k < 40; k++) begin
      req_act[2] = (k % 10 == 9);
      tick();
    end
    req_act = '0;
    chk("act_keepalive", 32'(grant8[2]), 32'h1);
    release_all();

    // Randomized traffic including aborts, stray done pulses and dest churn.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 8; i++) begin
        int r;
        req_done[i] = 1'b0;
        req_act[i]  = ($urandom_range(0, 3) == 0);
        r = int'($urandom_range(0, 9));
        if (!req_valid[i]) begin
          if (r < 3) begin
            req_valid[i] = 1'b1;
            req_dest[i]  = 3'($urandom_range(0, 7));
          end
        end else if (eg[0][i]) begin
          if (r < 2) begin req_done[i] = 1'b1; req_valid[i] = 1'b0; end
          else if (r == 2) req_valid[i] = 1'b0;
          else if (r == 3) req_dest[i] = 3'($urandom_range(0, 7));
        end else begin
          if (r == 0) req_valid[i] = 1'b0;
          else if (r == 1) req_done[i] = 1'b1;
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
